// File: rtl/mem_responder.sv
// Shared instruction/data memory with fixed-latency access: one access at a time,
// data port wins ties, and the CPU is stalled while a request is pending or in flight.
module mem_responder #(
  parameter int LAT    = 4,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_re,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_rdy,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_rdy,
  output logic        stall,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds its re/we (and operands) high until it sees its
  // rdy pulse, which lasts exactly one cycle; rdata is valid during that pulse
  // and keeps its value until the next read on the same port.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                port_d;
  logic                op_w;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         wdata;
  logic [15:0]         mem [2**ADDR_W];
  logic                req_d;
  logic                req_any;
  logic                commit;
  logic                unused_addr_hi;

  assign req_d   = d_re | d_we;
  assign req_any = req_d | i_re;
  assign commit  = (state == BUSY) && (cnt == 4'd0);

  // Address bits above ADDR_W wrap around and are intentionally ignored.
  assign unused_addr_hi = ^{i_addr[15:ADDR_W], d_addr[15:ADDR_W]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      port_d  <= 1'b0;
      op_w    <= 1'b0;
      addr    <= '0;
      wdata   <= 16'h0000;
      i_rdata <= 16'h0000;
      d_rdata <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_d) begin
            port_d <= 1'b1;
            op_w   <= d_we;
            addr   <= d_addr[ADDR_W-1:0];
            wdata  <= d_wdata;
            cnt    <= 4'(LAT - 1);
          end else if (i_re) begin
            port_d <= 1'b0;
            op_w   <= 1'b0;
            addr   <= i_addr[ADDR_W-1:0];
            cnt    <= 4'(LAT - 1);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!op_w) begin
            if (port_d) d_rdata <= mem[addr];
            else        i_rdata <= mem[addr];
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; a reset during BUSY suppresses the pending write.
  always_ff @(posedge clk) begin
    if (rst && commit && op_w) mem[addr] <= wdata;
  end

  assign i_rdy     = (state == DONE) && !port_d;
  assign d_rdy     = (state == DONE) && port_d;
  assign stall     = rst && ((state == BUSY) || ((state == IDLE) && req_any));
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized transaction-level bench for mem_responder: the model predicts completion
// cycles, stall and read data from the access rules; a LAT=1 instance covers back-to-back reads.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_re = 1'b0;
  logic        d_re = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;

  logic [15:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
  logic        i_rdy0, d_rdy0, stall0, i_rdy1, d_rdy1, stall1;
  logic [1:0]  fsm_state0, fsm_state1;

  bit          use1 = 1'b0;
  int          cur_lat = 4;
  logic [15:0] o_i_rdata, o_d_rdata;
  logic        o_i_rdy, o_d_rdy, o_stall;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] mem_m [1024];
  logic [15:0] last_i, last_d;

  always #5 clk = ~clk;

  mem_responder #(.LAT(4), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata0), .i_rdy(i_rdy0),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_rdy(d_rdy0), .stall(stall0), .fsm_state(fsm_state0)
  );

  mem_responder #(.LAT(1), .ADDR_W(10)) dut1 (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata1), .i_rdy(i_rdy1),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_rdy(d_rdy1), .stall(stall1), .fsm_state(fsm_state1)
  );

  assign o_i_rdata = use1 ? i_rdata1 : i_rdata0;
  assign o_d_rdata = use1 ? d_rdata1 : d_rdata0;
  assign o_i_rdy   = use1 ? i_rdy1   : i_rdy0;
  assign o_d_rdy   = use1 ? d_rdy1   : d_rdy0;
  assign o_stall   = use1 ? stall1   : stall0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access group starting in an IDLE cycle (k=0). d_op: 0 none, 1 read,
  // 2 write, 3 read+write (treated as write). gap adds a request-free cycle.
  task automatic do_access(input bit ui, input logic [1:0] d_op, input logic [15:0] ia,
                           input logic [15:0] da, input logic [15:0] wd, input bit gap);
    bit ud, dw;
    int dd, is, id, last;
    logic [15:0] e_stall, e_irdy, e_drdy;
    ud   = (d_op != 2'd0);
    dw   = d_op[1];
    dd   = ud ? cur_lat + 1 : -1;
    is   = ud ? cur_lat + 2 : 0;
    id   = ui ? is + cur_lat + 1 : -1;
    last = ui ? id : dd;
    for (int k = 0; k <= last + (gap ? 1 : 0); k++) begin
      i_re    = ui && (k <= id);
      d_we    = ud && dw && (k <= dd);
      d_re    = ud && (k <= dd) && (!dw || d_op[0]);
      i_addr  = (k == is) ? ia : 16'($urandom);
      d_addr  = (k == 0) ? da : 16'($urandom);
      d_wdata = (k == 0) ? wd : 16'($urandom);
      @(negedge clk);
      if (k == dd) begin
        if (dw) mem_m[da[9:0]] = wd;
        else    last_d = mem_m[da[9:0]];
      end
      if (k == id) last_i = mem_m[ia[9:0]];
      e_stall = {15'd0, (k <= last) && (k != dd) && (k != id)};
      e_irdy  = {15'd0, k == id};
      e_drdy  = {15'd0, k == dd};
      check($sformatf("stall k=%0d", k), {15'd0, o_stall}, e_stall);
      check($sformatf("i_rdy k=%0d", k), {15'd0, o_i_rdy}, e_irdy);
      check($sformatf("d_rdy k=%0d", k), {15'd0, o_d_rdy}, e_drdy);
      check($sformatf("i_rdata k=%0d", k), o_i_rdata, last_i);
      check($sformatf("d_rdata k=%0d", k), o_d_rdata, last_d);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    i_re = 1'b0;
    d_re = 1'b0;
    d_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    last_i = 16'h0000;
    last_d = 16'h0000;
    check("reset stall", {15'd0, o_stall}, 16'h0);
    check("reset i_rdy", {15'd0, o_i_rdy}, 16'h0);
    check("reset d_rdy", {15'd0, o_d_rdy}, 16'h0);
    check("reset i_rdata", o_i_rdata, 16'h0000);
    check("reset d_rdata", o_d_rdata, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Write request interrupted by reset two cycles in: nothing commits, no rdy.
  task automatic abort_write(input logic [15:0] a, input logic [15:0] v);
    for (int k = 0; k <= 4; k++) begin
      rst     = (k < 2 || k == 4);
      d_we    = (k < 2);
      d_addr  = (k == 0) ? a : 16'($urandom);
      d_wdata = (k == 0) ? v : 16'($urandom);
      @(negedge clk);
      check($sformatf("abort stall k=%0d", k), {15'd0, o_stall}, {15'd0, k < 2});
      check($sformatf("abort d_rdy k=%0d", k), {15'd0, o_d_rdy}, 16'h0);
      if (k >= 3) check($sformatf("abort d_rdata k=%0d", k), o_d_rdata, 16'h0000);
      @(posedge clk);
      #1;
    end
    last_i = 16'h0000;
    last_d = 16'h0000;
  endtask

  initial begin
    bit          ui;
    logic [1:0]  dop;
    logic [15:0] v;
    last_i = 16'h0000;
    last_d = 16'h0000;

    do_reset();
    do_access(1'b0, 2'd2, 16'h0, 16'h0010, 16'hBEEF, 1'b1);
    do_access(1'b0, 2'd1, 16'h0, 16'h0010, 16'h0, 1'b1);
    do_access(1'b1, 2'd2, 16'h0010, 16'h0020, 16'h1234, 1'b1);
    do_access(1'b0, 2'd1, 16'h0, 16'h0020, 16'h0, 1'b1);
    do_access(1'b0, 2'd2, 16'h0, 16'h0405, 16'hA5A5, 1'b1);
    do_access(1'b0, 2'd1, 16'h0, 16'h0005, 16'h0, 1'b1);
    do_access(1'b1, 2'd0, 16'hFC05, 16'h0, 16'h0, 1'b1);
    do_access(1'b0, 2'd2, 16'h0, 16'h0030, 16'h1111, 1'b1);
    abort_write(16'h0030, 16'h2222);
    do_access(1'b0, 2'd1, 16'h0, 16'h0030, 16'h0, 1'b1);
    do_access(1'b1, 2'd0, 16'h0030, 16'h0, 16'h0, 1'b1);

    for (int a = 0; a < 1024; a++) begin
      v = 16'($urandom);
      do_access(1'b0, 2'd2, 16'h0, {6'($urandom), 10'(a)}, v, 1'b0);
    end

    repeat (120) begin
      ui  = 1'($urandom_range(0, 1));
      dop = 2'($urandom_range(0, 3));
      if (!ui && dop == 2'd0) dop = 2'd1;
      do_access(ui, dop, 16'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)));
    end

    use1    = 1'b1;
    cur_lat = 1;
    do_reset();
    do_access(1'b0, 2'd2, 16'h0, 16'h0000, 16'h5A01, 1'b1);
    do_access(1'b0, 2'd2, 16'h0, 16'h0001, 16'hC3D2, 1'b1);
    do_access(1'b1, 2'd0, 16'h0000, 16'h0, 16'h0, 1'b0);
    do_access(1'b1, 2'd0, 16'h0001, 16'h0, 16'h0, 1'b1);
    repeat (30) begin
      ui  = 1'($urandom_range(0, 1));
      dop = 2'($urandom_range(0, 3));
      if (!ui && dop == 2'd0) dop = 2'd1;
      do_access(ui, dop, {15'($urandom), 1'($urandom)} & 16'hFC01,
                {15'($urandom), 1'($urandom)} & 16'hFC01, 16'($urandom),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
